ring_osc_freq_counter: RTL and testbench

Measurement end of the on-chip ring-oscillator experiment: counts rising edges of an asynchronous oscillator tap over a fixed gate window of clk cycles, then latches the result. The latched result goes out through an 8-bit byte-selected bus to the dedicated outputs. Together with the oscillator it measures per-stage delay: edges/window gives f_osc, and delay = 1/(2·N·f_osc). The block sits beside the oscillator in the top-level wrapper; osc_in is normally fed from an external or on-chip divided tap.

---
 rtl/ring_osc_freq_counter_pkg.sv | 21 ++
 rtl/sync_edge_det.sv | 30 +++
 rtl/ring_osc_freq_counter.sv | 138 +++++++++++++
 tb/tb_ring_osc_freq_counter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_osc_freq_counter_pkg.sv
// Shared types for the ring-oscillator frequency counter: FSM states,
// byte-select encodings and the status-byte packing helper.
package ring_osc_freq_counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LATCH   = 2'd3
  } state_e;

  localparam logic [1:0] SEL_LO   = 2'd0;
  localparam logic [1:0] SEL_HI   = 2'd1;
  localparam logic [1:0] SEL_STAT = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  function automatic logic [7:0] stat_byte(input logic ovf, input logic busy);
    return {ovf, busy, 6'b000000};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for the asynchronous oscillator tap plus a "prev"
// flop for rising-edge detection; flush masks edges while the chain primes.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic osc_in,
  input  logic flush,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain and previous-sample flop keep sampling even while
  // flushed, so prev is already valid on the first counted cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], osc_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_r[SYNC_STAGES-1] & ~prev_r & ~flush;

endmodule

// File: rtl/ring_osc_freq_counter.sv
// Gated edge counter for a ring-oscillator tap: counts synchronized rising
// edges over GATE_CYCLES clocks and latches a saturating result.
module ring_osc_freq_counter
  import ring_osc_freq_counter_pkg::*;
#(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       osc_in,
  input  logic       start,
  input  logic       continuous,
  input  logic [1:0] byte_sel,
  output logic [7:0] count_out,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int TMR_MAX    = (GATE_CYCLES > ARM_CYCLES) ? GATE_CYCLES : ARM_CYCLES;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] ARM_LOAD  = TMR_W'(ARM_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e             state_r, state_s;
  logic [TMR_W-1:0]   tmr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               cnt_ovf_r;
  logic [CNT_W-1:0]   result_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;
  logic               rise_s;
  logic [15:0]        res_ext_s;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .osc_in     (osc_in),
    .flush      (state_r != MEASURE),
    .rise_pulse (rise_s)
  );

  // Next-state decode; ARM and MEASURE end when the shared timer hits zero.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start)        state_s = ARM;     else state_s = IDLE;
      ARM:     if (tmr_r == '0)  state_s = MEASURE; else state_s = ARM;
      MEASURE: if (tmr_r == '0)  state_s = LATCH;   else state_s = MEASURE;
      LATCH:   if (continuous)   state_s = ARM;     else state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and phase timer, reloaded on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      tmr_r   <= '0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) begin
        case (state_s)
          ARM:     tmr_r <= ARM_LOAD;
          MEASURE: tmr_r <= GATE_LOAD;
          default: tmr_r <= '0;
        endcase
      end else if (tmr_r != '0) begin
        tmr_r <= tmr_r - TMR_W'(1);
      end
    end
  end

  // Saturating edge counter; an increment attempted at all-ones is remembered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      cnt_ovf_r <= 1'b0;
    end else if (state_s == ARM && state_r != ARM) begin
      cnt_r     <= '0;
      cnt_ovf_r <= 1'b0;
    end else if (state_r == MEASURE && rise_s) begin
      if (cnt_r == CNT_MAX) begin
        cnt_ovf_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Result capture happens only in LATCH so readers see the last full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= '0;
      ovf_r    <= 1'b0;
    end else if (state_r == LATCH) begin
      result_r <= cnt_r;
      ovf_r    <= cnt_ovf_r;
    end
  end

  // Status flags registered from the next state so they align with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == LATCH);
    end
  end

  assign res_ext_s = 16'(result_r);

  // Byte-select read mux over registered state.
  always_comb begin
    count_out = 8'h00;
    case (byte_sel)
      SEL_LO:   count_out = res_ext_s[7:0];
      SEL_HI:   count_out = res_ext_s[15:8];
      SEL_STAT: count_out = stat_byte(ovf_r, busy_r);
      SEL_ZERO: count_out = 8'h00;
      default:  count_out = 8'h00;
    endcase
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Directed/randomized bench: periodic osc waveforms whose period divides the
// gate window, so the expected count is simply window / period.
module tb_ring_osc_freq_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       osc;
  logic       start_a, start_b;
  logic       continuous;
  logic [1:0] byte_sel;
  logic [7:0] count_out_a, count_out_b;
  logic       busy_a, busy_b, done_a, done_b, overflow_a, overflow_b;

  int n_checks = 0;
  int n_fail   = 0;

  int osc_p = 8;
  int osc_h = 4;
  int osc_ph = 0;
  bit osc_const_mode = 1'b0;
  logic osc_const = 1'b0;

  int periods[5] = '{4, 8, 16, 32, 64};

  ring_osc_freq_counter #(.GATE_CYCLES(64), .CNT_W(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start_a), .continuous(continuous),
    .byte_sel(byte_sel), .count_out(count_out_a), .busy(busy_a), .done(done_a),
    .overflow(overflow_a)
  );

  ring_osc_freq_counter #(.GATE_CYCLES(1200), .CNT_W(9), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start_b), .continuous(1'b0),
    .byte_sel(byte_sel), .count_out(count_out_b), .busy(busy_b), .done(done_b),
    .overflow(overflow_b)
  );

  initial forever #5 clk = ~clk;

  // Oscillator model: square wave of period osc_p with osc_h high cycles.
  initial begin
    osc = 1'b0;
    forever begin
      @(negedge clk);
      if (osc_const_mode) begin
        osc = osc_const;
      end else begin
        osc = (osc_ph < osc_h);
        osc_ph = (osc_ph + 1) % osc_p;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic dn(input int w);
    return (w != 0) ? done_b : done_a;
  endfunction

  task automatic set_osc(input int p, input int h);
    osc_const_mode = 1'b0;
    osc_p  = p;
    osc_h  = h;
    osc_ph = $urandom_range(p - 1);
    repeat (p + 6) tick();
  endtask

  task automatic set_const(input logic v);
    osc_const_mode = 1'b1;
    osc_const = v;
    repeat (6) tick();
  endtask

  task automatic wait_done(input int w, input int budget, output int n);
    n = 0;
    while (n < budget && !dn(w)) begin
      tick();
      n++;
    end
    if (!dn(w)) n = -1;
  endtask

  // Start cycle is cycle 1; returns the cycle number in which done is seen.
  task automatic measure(input int w, input int budget, output int lat);
    int n;
    if (w != 0) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    wait_done(w, budget, n);
    lat = (n < 0) ? -1 : n + 2;
  endtask

  task automatic read_bytes(input int w, output logic [7:0] lo, output logic [7:0] hi,
                            output logic [7:0] st);
    byte_sel = 2'd0; #1; lo = (w != 0) ? count_out_b : count_out_a;
    byte_sel = 2'd1; #1; hi = (w != 0) ? count_out_b : count_out_a;
    byte_sel = 2'd2; #1; st = (w != 0) ? count_out_b : count_out_a;
  endtask

  initial begin
    int lat, n, p, h, exp_cnt, extra;
    logic [7:0] lo, hi, st;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; continuous = 1'b0; byte_sel = 2'd0;
    repeat (3) tick();
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    read_bytes(0, lo, hi, st);
    chk("reset_lo", 32'(lo), 32'h0);
    chk("reset_hi", 32'(hi), 32'h0);
    chk("reset_stat", 32'(st), 32'h0);
    byte_sel = 2'd3; #1;
    chk("reset_zero", 32'(count_out_a), 32'h0);
    rst = 1'b0;
    tick();

    // Basic measurement: period 8 over 64 cycles.
    set_osc(8, 4);
    measure(0, 200, lat);
    chk("lat_p8", 32'(lat), 32'd69);
    tick();
    chk("done_one_cycle", 32'(done_a), 32'd0);
    chk("busy_after", 32'(busy_a), 32'd0);
    read_bytes(0, lo, hi, st);
    chk("p8_lo", 32'(lo), 32'h08);
    chk("p8_hi", 32'(hi), 32'h00);
    chk("p8_ovf", 32'(overflow_a), 32'd0);
    byte_sel = 2'd3; #1;
    chk("sel3_zero", 32'(count_out_a), 32'h0);

    // Constant inputs yield zero counts but still complete.
    set_const(1'b0);
    measure(0, 200, lat);
    chk("lat_const0", 32'(lat), 32'd69);
    tick();
    read_bytes(0, lo, hi, st);
    chk("const0_lo", 32'(lo), 32'h00);
    set_const(1'b1);
    measure(0, 200, lat);
    chk("lat_const1", 32'(lat), 32'd69);
    tick();
    read_bytes(0, lo, hi, st);
    chk("const1_lo", 32'(lo), 32'h00);

    // Random periods, duty cycles and phases.
    for (int i = 0; i < 6; i++) begin
      p = periods[$urandom_range(4)];
      h = $urandom_range(p - 2, 2);
      set_osc(p, h);
      exp_cnt = 64 / p;
      measure(0, 200, lat);
      chk("rand_lat", 32'(lat), 32'd69);
      tick();
      read_bytes(0, lo, hi, st);
      chk("rand_lo", 32'(lo), 32'(exp_cnt));
      chk("rand_hi", 32'(hi), 32'h00);
    end

    // Continuous mode: period 16 -> 4 edges per window, done every 68 cycles.
    set_osc(16, 8);
    continuous = 1'b1;
    measure(0, 200, lat);
    chk("cont_lat", 32'(lat), 32'd69);
    for (int k = 0; k < 3; k++) begin
      tick();
      read_bytes(0, lo, hi, st);
      chk("cont_lo", 32'(lo), 32'h04);
      wait_done(0, 200, n);
      chk("cont_period", 32'(n + 1), 32'd68);
    end
    tick();
    repeat (20) tick();
    continuous = 1'b0;
    wait_done(0, 200, n);
    chk("cont_last_period", 32'(n + 21), 32'd68);
    tick();
    chk("cont_idle", 32'(busy_a), 32'd0);
    extra = 0;
    repeat (80) begin
      tick();
      if (done_a) extra++;
    end
    chk("cont_no_extra", 32'(extra), 32'd0);
    read_bytes(0, lo, hi, st);
    chk("cont_final_lo", 32'(lo), 32'h04);

    // Start while busy is ignored.
    set_osc(8, 4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (30) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, 200, n);
    chk("restart_lat", 32'(n < 0 ? -1 : n + 33), 32'd69);
    extra = 0;
    repeat (80) begin
      tick();
      if (done_a) extra++;
    end
    chk("restart_single_done", 32'(extra), 32'd0);
    read_bytes(0, lo, hi, st);
    chk("restart_lo", 32'(lo), 32'h08);

    // Reset mid-measurement aborts and clears the result.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (40) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    read_bytes(0, lo, hi, st);
    chk("abort_lo", 32'(lo), 32'h00);
    chk("abort_stat", 32'(st), 32'h00);
    repeat (3) tick();
    rst = 1'b0;
    extra = 0;
    repeat (80) begin
      tick();
      if (done_a) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);
    measure(0, 200, lat);
    chk("post_abort_lat", 32'(lat), 32'd69);
    tick();
    read_bytes(0, lo, hi, st);
    chk("post_abort_lo", 32'(lo), 32'h08);

    // Narrow counter saturation: 600 edges into a 9-bit counter.
    set_osc(2, 1);
    measure(1, 1300, lat);
    chk("sat_lat", 32'(lat), 32'd1205);
    tick();
    read_bytes(1, lo, hi, st);
    chk("sat_lo", 32'(lo), 32'hFF);
    chk("sat_hi", 32'(hi), 32'h01);
    chk("sat_stat", 32'(st), 32'h80);
    chk("sat_ovf", 32'(overflow_b), 32'd1);

    // Overflow is per result: a later in-range window clears it.
    set_osc(4, 2);
    measure(1, 1300, lat);
    chk("b300_lat", 32'(lat), 32'd1205);
    tick();
    read_bytes(1, lo, hi, st);
    chk("b300_lo", 32'(lo), 32'(300 % 256));
    chk("b300_hi", 32'(hi), 32'(300 / 256));
    chk("b300_stat", 32'(st), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
